// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle shared by the fetch stage and the memory port.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, talks to imem and loads the IF/ID register,
// absorbing variable memory latency, load-use stalls and downstream redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_stage_if.master imem,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);

    typedef enum logic [1:0] {REQ, DRAIN, BUF} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_pendPc;
    logic [31:0] r_bufInstr;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_pcNext;
    logic [31:0] w_loadInstr;
    logic        w_load;
    logic        w_bubble;

    assign w_pcPlus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) r_state <= REQ;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            REQ: begin
                if (redirect && !imem.imem_valid)
                    w_nextState = DRAIN;
                else if (!redirect && imem.imem_valid && stall)
                    w_nextState = BUF;
            end
            DRAIN:   if (imem.imem_valid) w_nextState = REQ;
            BUF:     if (redirect || !stall) w_nextState = REQ;
            default: w_nextState = REQ;
        endcase
    end

    // Redirect beats stall for IF/ID; stall otherwise freezes it, else load or insert a bubble.
    always_comb begin
        imem.imem_req  = (r_state != BUF) && !rst;
        imem.imem_addr = r_pc;
        w_load         = 1'b0;
        w_bubble       = 1'b0;
        w_loadInstr    = imem.imem_rdata;
        w_pcNext       = r_pc;
        if (redirect) begin
            w_bubble = 1'b1;
        end else if (!stall) begin
            case (r_state)
                REQ: begin
                    w_load   = imem.imem_valid;
                    w_bubble = !imem.imem_valid;
                end
                BUF: begin
                    w_load      = 1'b1;
                    w_loadInstr = r_bufInstr;
                end
                default: w_bubble = 1'b1;
            endcase
        end
        if (w_load)
            w_pcNext = w_pcPlus4;
        case (r_state)
            REQ:     if (redirect && imem.imem_valid) w_pcNext = redirect_pc;
            DRAIN:   if (imem.imem_valid) w_pcNext = redirect ? redirect_pc : r_pendPc;
            BUF:     if (redirect) w_pcNext = redirect_pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pendPc   <= 32'd0;
            r_bufInstr <= 32'd0;
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd4;
            ifid_instr <= NOP_INSTR;
        end else begin
            r_pc <= w_pcNext;
            // The newest redirect seen while a killed fetch is in flight wins.
            if (redirect && r_state != BUF)
                r_pendPc <= redirect_pc;
            if (r_state == REQ && imem.imem_valid && stall && !redirect)
                r_bufInstr <= imem.imem_rdata;
            if (w_load) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= r_pc;
                ifid_pc4   <= w_pcPlus4;
                ifid_instr <= w_loadInstr;
            end else if (w_bubble) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset/wrap sequences,
// then random traffic compared against a transaction-level fetch model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    int errCount   = 0;
    int checkCount = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        valid;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic        expReq;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[$];

    // Instruction memory contents: a scrambled function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic vl, input logic ev, input logic [31:0] epc,
                                input logic isNop, input logic er, input logic [31:0] ea);
        vec_t v;
        v.stall = st; v.redirect = rd; v.rpc = rpc; v.valid = vl;
        v.expValid = ev; v.expPc = epc; v.expInstr = isNop ? NOP : memWord(epc);
        v.expReq = er; v.expAddr = ea;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [31:0] einstr, input logic er, input logic [31:0] ea);
        checkField({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, ev});
        checkField({tag, ".ifid_pc"}, ifid_pc, epc);
        checkField({tag, ".ifid_pc4"}, ifid_pc4, epc + 32'd4);
        checkField({tag, ".ifid_instr"}, ifid_instr, einstr);
        checkField({tag, ".imem_req"}, {31'd0, bus.imem_req}, {31'd0, er});
        checkField({tag, ".imem_addr"}, bus.imem_addr, ea);
    endtask

    // Drive one cycle of inputs on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc, input logic vl);
        @(negedge clk);
        stall          = st;
        redirect       = rd;
        redirect_pc    = rpc;
        bus.imem_valid = vl;
        bus.imem_rdata = memWord(bus.imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        bus.imem_valid = 1'b0; bus.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'd0, NOP, 1'b0, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkField("reset.req_after", {31'd0, bus.imem_req}, 32'd1);
        checkField("reset.addr_after", bus.imem_addr, RESET_PC);
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].valid);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expInstr, vecs[i].expReq, vecs[i].expAddr);
        end
    endtask

    // Reference model: a fetch is either outstanding-live, outstanding-killed (with a
    // pending target) or already returned and parked while decode is stalled.
    logic [31:0] mPc, mTarget, mBufWord, mIfPc, mIfInstr;
    logic        mKill, mHasBuf, mIfValid;

    task automatic modelReset();
        mPc = RESET_PC; mTarget = 32'd0; mBufWord = 32'd0; mKill = 1'b0; mHasBuf = 1'b0;
        mIfValid = 1'b0; mIfPc = 32'd0; mIfInstr = NOP;
    endtask

    task automatic modelStep(input logic st, input logic rd, input logic [31:0] rpc, input logic vl);
        logic        deliver;
        logic [31:0] word;
        logic [31:0] fetchPc;
        deliver = 1'b0; word = 32'd0; fetchPc = mPc;
        if (mHasBuf) begin
            if (rd) begin
                mHasBuf = 1'b0; mPc = rpc;
            end else if (!st) begin
                deliver = 1'b1; word = mBufWord; mHasBuf = 1'b0;
            end
        end else if (mKill) begin
            if (rd) mTarget = rpc;
            if (vl) begin
                mPc = mTarget; mKill = 1'b0;
            end
        end else if (rd) begin
            if (vl) mPc = rpc;
            else begin
                mKill = 1'b1; mTarget = rpc;
            end
        end else if (vl) begin
            if (st) begin
                mHasBuf = 1'b1; mBufWord = memWord(mPc);
            end else begin
                deliver = 1'b1; word = memWord(mPc);
            end
        end
        if (rd) begin
            mIfValid = 1'b0; mIfInstr = NOP;
        end else if (!st) begin
            if (deliver) begin
                mIfValid = 1'b1; mIfPc = fetchPc; mIfInstr = word; mPc = fetchPc + 32'd4;
            end else begin
                mIfValid = 1'b0; mIfInstr = NOP;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // st rd rpc valid | v pc nop req addr
        vecs.push_back(mk(0,0,0,1, 1,32'h0,0, 1,32'h4));
        vecs.push_back(mk(0,0,0,1, 1,32'h4,0, 1,32'h8));
        vecs.push_back(mk(1,0,0,1, 1,32'h4,0, 0,32'h8));
        vecs.push_back(mk(1,0,0,0, 1,32'h4,0, 0,32'h8));
        vecs.push_back(mk(1,0,0,0, 1,32'h4,0, 0,32'h8));
        vecs.push_back(mk(0,0,0,0, 1,32'h8,0, 1,32'hC));
        vecs.push_back(mk(0,0,0,0, 0,32'h8,1, 1,32'hC));
        vecs.push_back(mk(0,0,0,0, 0,32'h8,1, 1,32'hC));
        vecs.push_back(mk(0,0,0,1, 1,32'hC,0, 1,32'h10));
        vecs.push_back(mk(0,1,32'h100,0, 0,32'hC,1, 1,32'h10));
        vecs.push_back(mk(0,0,0,0, 0,32'hC,1, 1,32'h10));
        vecs.push_back(mk(0,0,0,1, 0,32'hC,1, 1,32'h100));
        vecs.push_back(mk(0,0,0,1, 1,32'h100,0, 1,32'h104));
        vecs.push_back(mk(0,1,32'h200,0, 0,32'h100,1, 1,32'h104));
        vecs.push_back(mk(0,1,32'h300,0, 0,32'h100,1, 1,32'h104));
        vecs.push_back(mk(0,0,0,1, 0,32'h100,1, 1,32'h300));
        vecs.push_back(mk(0,0,0,1, 1,32'h300,0, 1,32'h304));
        vecs.push_back(mk(1,1,32'hFFFF_FFFC,1, 0,32'h300,1, 1,32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,0,1, 1,32'hFFFF_FFFC,0, 1,32'h0));
        vecs.push_back(mk(0,1,32'h80,0, 0,32'hFFFF_FFFC,1, 1,32'h0));
        vecs.push_back(mk(1,1,32'h40,1, 0,32'hFFFF_FFFC,1, 1,32'h40));
        vecs.push_back(mk(1,0,0,1, 0,32'hFFFF_FFFC,1, 0,32'h40));
        // after a reset issued while parked in BUF
        vecs.push_back(mk(0,0,0,1, 1,32'h0,0, 1,32'h4));
        vecs.push_back(mk(1,0,0,1, 1,32'h0,0, 0,32'h4));
        vecs.push_back(mk(1,1,32'h502,0, 0,32'h0,1, 1,32'h502));
        vecs.push_back(mk(0,0,0,1, 1,32'h502,0, 1,32'h506));

        doReset();
        runVectors(0, 22);
        doReset();
        runVectors(22, vecs.size());

        doReset();
        modelReset();
        for (int c = 0; c < 600; c++) begin
            logic        st, rd, vl;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + {29'd0, 3'($urandom_range(0, 7))}
                                              : ($urandom & 32'h0000_FFFC);
            vl  = !mHasBuf && ($urandom_range(0, 9) < 6);
            applyStimulus(st, rd, rpc, vl);
            modelStep(st, rd, rpc, vl);
            checkOutput($sformatf("rand%0d", c), mIfValid, mIfPc, mIfInstr, !mHasBuf, mPc);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
